clk_gate_ctrl: RTL

Activity-based clock-enable controller that produces the enable consumed by `clock_gating_model` (`i_clock_en`). It runs on the free-running clock, watches a busy/activity indication from the downstream domain, and drops the enable after a programmable run of idle cycles. It re-enables the clock on any wake source, then holds a fixed warm-up before declaring the domain ready. It also keeps a saturating count of gating events for debug.

---
 rtl/clk_gate_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/clk_gate_ctrl.sv
// Activity-based clock-enable controller: gates after an idle run,
// re-enables on any wake source, then holds a warm-up before ready.
module clk_gate_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_busy,
   input  logic        i_wake_req,
   input  logic        i_force_on,
   output logic        o_clock_en,
   output logic        o_ready,
   output logic        o_gated,
   output logic [15:0] o_gate_events
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      GATED = 2'd1,
      WAKE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LP_IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_idle_cnt;
   logic [CNT_W-1:0]   w_idle_nxt;
   logic [CNT_W-1:0]   r_wake_cnt;
   logic [CNT_W-1:0]   w_wake_nxt;
   logic [15:0]        r_gate_events;
   logic [15:0]        w_events_nxt;
   logic               r_clock_en;
   logic               r_ready;
   logic               r_gated;
   logic               w_idle;

   assign w_idle = ~(i_busy | i_wake_req | i_force_on);

   always_comb begin
      w_state_nxt  = r_state;
      w_idle_nxt   = r_idle_cnt;
      w_wake_nxt   = r_wake_cnt;
      w_events_nxt = r_gate_events;
      unique case (r_state)
         RUN: begin
            if (!w_idle) begin
               w_idle_nxt = '0;
            end else if (r_idle_cnt == LP_IDLE_LAST) begin
               w_state_nxt = GATED;
               w_idle_nxt  = '0;
               if (r_gate_events != 16'hFFFF) begin
                  w_events_nxt = r_gate_events + 16'd1;
               end
            end else begin
               w_idle_nxt = r_idle_cnt + 1'b1;
            end
         end
         GATED: begin
            if (!w_idle) begin
               w_state_nxt = WAKE;
               w_wake_nxt  = '0;
            end
         end
         WAKE: begin
            // Warm-up always runs to completion regardless of inputs
            if (r_wake_cnt == LP_WAKE_LAST) begin
               w_state_nxt = RUN;
               w_idle_nxt  = '0;
               w_wake_nxt  = '0;
            end else begin
               w_wake_nxt = r_wake_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_idle_nxt  = '0;
            w_wake_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state       <= RUN;
         r_idle_cnt    <= '0;
         r_wake_cnt    <= '0;
         r_gate_events <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_idle_cnt    <= w_idle_nxt;
         r_wake_cnt    <= w_wake_nxt;
         r_gate_events <= w_events_nxt;
      end
   end

   // Dedicated output flops keep o_clock_en free of state-decode glitches
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_clock_en <= 1'b1;
         r_ready    <= 1'b1;
         r_gated    <= 1'b0;
      end else begin
         r_clock_en <= (w_state_nxt != GATED);
         r_ready    <= (w_state_nxt == RUN);
         r_gated    <= (w_state_nxt == GATED);
      end
   end

   assign o_clock_en    = r_clock_en;
   assign o_ready       = r_ready;
   assign o_gated       = r_gated;
   assign o_gate_events = r_gate_events;

endmodule
